// File: rtl/rx_cmd_pkg.sv
// -----------------------------------------------------------------------------
// rx_cmd_pkg
// Shared definitions for the serial command decoder:
//   - command byte values that open a frame
//   - Cmd_op encodings seen by the command consumer
//   - FSM state encoding
//   - decode_cmd(): maps a command byte to its op and first field state
//   - timer_width(): counter width able to hold a given timeout value
// -----------------------------------------------------------------------------
package rx_cmd_pkg;

    // Command bytes that start a frame
    localparam logic [7:0] CMD_BYTE_WR      = 8'hAA;
    localparam logic [7:0] CMD_BYTE_RD      = 8'hBB;
    localparam logic [7:0] CMD_BYTE_ALU     = 8'hCC;
    localparam logic [7:0] CMD_BYTE_ALU_NOP = 8'hDD;

    // Operation encoding presented on Cmd_op
    typedef enum logic [1:0] {
        OP_WR      = 2'b00,
        OP_RD      = 2'b01,
        OP_ALU     = 2'b10,
        OP_ALU_NOP = 2'b11
    } cmd_op_e;

    // Decoder FSM states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        GET_OPA  = 3'd3,
        GET_OPB  = 3'd4,
        GET_FUNC = 3'd5,
        ISSUE    = 3'd6
    } state_e;

    // Result of looking up a command byte
    typedef struct packed {
        logic    known;        // byte is one of the four command bytes
        cmd_op_e op;           // operation it selects
        state_e  first_state;  // first field state of the frame
    } cmd_decode_t;

    function automatic cmd_decode_t decode_cmd(input logic [7:0] cmd_byte);
        cmd_decode_t d;
        d.known       = 1'b1;
        d.op          = OP_WR;
        d.first_state = IDLE;
        case (cmd_byte)
            CMD_BYTE_WR: begin
                d.op          = OP_WR;
                d.first_state = GET_ADDR;
            end
            CMD_BYTE_RD: begin
                d.op          = OP_RD;
                d.first_state = GET_ADDR;
            end
            CMD_BYTE_ALU: begin
                d.op          = OP_ALU;
                d.first_state = GET_OPA;
            end
            CMD_BYTE_ALU_NOP: begin
                d.op          = OP_ALU_NOP;
                d.first_state = GET_FUNC;
            end
            default: begin
                d.known = 1'b0;
            end
        endcase
        return d;
    endfunction

    // Bits needed to count from 0 up to and including max_count (at least 1)
    function automatic int timer_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Inter-byte idle counter for the command decoder. Counts enabled cycles
// since the last clear and saturates at Timeout, so a long stall never wraps
// back to a small value and hides the timeout.
//
// Ports
//   CLK      in   clock
//   Reset    in   synchronous active-low reset, clears the count
//   clear    in   restart counting from 0 (has priority over enable)
//   enable   in   count this cycle
//   expired  out  count has reached Timeout while counting is enabled
// -----------------------------------------------------------------------------
module frame_timer
    import rx_cmd_pkg::*;
#(
    parameter int Timeout = 255
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CntWidth = timer_width(Timeout);
    localparam logic [CntWidth-1:0] CountMax = CntWidth'(Timeout);

    logic [CntWidth-1:0] count_reg;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != CountMax)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Gated with enable so a stale saturated count outside a frame is inert.
    assign expired = enable && (count_reg == CountMax);

endmodule

// File: rtl/rx_cmd_decoder.sv
// -----------------------------------------------------------------------------
// rx_cmd_decoder
// Assembles multi-byte command frames from a byte stream into a single
// decoded command with a valid/ready handshake.
//
// Frames (first byte is the command byte):
//   0xAA addr data        -> WR       (Cmd_op 00)
//   0xBB addr             -> RD       (Cmd_op 01)
//   0xCC opA opB func     -> ALU_OP   (Cmd_op 10)
//   0xDD func             -> ALU_NOP  (Cmd_op 11)
//
// Ports
//   CLK        in   clock
//   Reset      in   synchronous active-low reset
//   RX_data    in   received byte, Width bits
//   RX_valid   in   one-cycle strobe qualifying RX_data
//   Cmd_ready  in   consumer accepts the pending command
//   Cmd_valid  out  decoded command pending
//   Cmd_op     out  operation (see above)
//   Cmd_addr   out  register address, low Addr_Width bits of the address byte
//   Cmd_data   out  write data
//   Cmd_opA    out  ALU operand A
//   Cmd_opB    out  ALU operand B
//   Cmd_func   out  ALU function, low nibble of the function byte
//   Frame_err  out  one-cycle pulse: unknown command byte or inter-byte timeout
//   Ovf_err    out  one-cycle pulse: byte dropped while a command is pending
//
// Field registers only change when their own byte arrives, so fields that
// the current op does not use keep whatever the previous command left there.
// Width must be at least 8 so that the command bytes fit the bus.
// -----------------------------------------------------------------------------
module rx_cmd_decoder
    import rx_cmd_pkg::*;
#(
    parameter int Width      = 8,
    parameter int Addr_Width = 4,
    parameter int Timeout    = 255
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [Width-1:0]      RX_data,
    input  logic                  RX_valid,
    input  logic                  Cmd_ready,
    output logic                  Cmd_valid,
    output logic [1:0]            Cmd_op,
    output logic [Addr_Width-1:0] Cmd_addr,
    output logic [Width-1:0]      Cmd_data,
    output logic [Width-1:0]      Cmd_opA,
    output logic [Width-1:0]      Cmd_opB,
    output logic [3:0]            Cmd_func,
    output logic                  Frame_err,
    output logic                  Ovf_err
);

    state_e      state_reg;
    cmd_decode_t cmd_dec;
    logic        in_field;
    logic        timer_clear;
    logic        timer_expired;
    logic        frame_abort;

    assign cmd_dec  = decode_cmd(RX_data[7:0]);
    assign in_field = (state_reg inside {GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUNC});

    // The timer only runs while collecting field bytes. Holding it cleared
    // in IDLE and ISSUE means it always starts from 0 at the first field.
    assign timer_clear = RX_valid || !in_field;

    frame_timer #(
        .Timeout (Timeout)
    ) u_frame_timer (
        .CLK     (CLK),
        .Reset   (Reset),
        .clear   (timer_clear),
        .enable  (in_field),
        .expired (timer_expired)
    );

    // A byte landing in the expiry cycle still counts, so only a silent
    // expiry cycle aborts the frame.
    assign frame_abort = in_field && timer_expired && !RX_valid;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_reg <= IDLE;
            Cmd_valid <= 1'b0;
            Cmd_op    <= 2'b00;
            Cmd_addr  <= '0;
            Cmd_data  <= '0;
            Cmd_opA   <= '0;
            Cmd_opB   <= '0;
            Cmd_func  <= '0;
            Frame_err <= 1'b0;
            Ovf_err   <= 1'b0;
        end else begin
            Frame_err <= 1'b0;
            Ovf_err   <= 1'b0;

            if (frame_abort) begin
                Frame_err <= 1'b1;
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    // ISSUE shares the IDLE path once the handshake completes
                    // so a byte arriving with Cmd_ready starts the next frame
                    // without a dead cycle.
                    IDLE, ISSUE: begin
                        if ((state_reg == ISSUE) && !Cmd_ready) begin
                            if (RX_valid) begin
                                Ovf_err <= 1'b1;
                            end
                        end else begin
                            Cmd_valid <= 1'b0;
                            state_reg <= IDLE;
                            if (RX_valid) begin
                                if (cmd_dec.known) begin
                                    Cmd_op    <= cmd_dec.op;
                                    state_reg <= cmd_dec.first_state;
                                end else begin
                                    Frame_err <= 1'b1;
                                end
                            end
                        end
                    end

                    GET_ADDR: begin
                        if (RX_valid) begin
                            Cmd_addr <= RX_data[Addr_Width-1:0];
                            if (Cmd_op == OP_WR) begin
                                state_reg <= GET_DATA;
                            end else begin
                                state_reg <= ISSUE;
                                Cmd_valid <= 1'b1;
                            end
                        end
                    end

                    GET_DATA: begin
                        if (RX_valid) begin
                            Cmd_data  <= RX_data;
                            state_reg <= ISSUE;
                            Cmd_valid <= 1'b1;
                        end
                    end

                    GET_OPA: begin
                        if (RX_valid) begin
                            Cmd_opA   <= RX_data;
                            state_reg <= GET_OPB;
                        end
                    end

                    GET_OPB: begin
                        if (RX_valid) begin
                            Cmd_opB   <= RX_data;
                            state_reg <= GET_FUNC;
                        end
                    end

                    GET_FUNC: begin
                        if (RX_valid) begin
                            Cmd_func  <= RX_data[3:0];
                            state_reg <= ISSUE;
                            Cmd_valid <= 1'b1;
                        end
                    end

                    default: begin
                        state_reg <= IDLE;
                        Cmd_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_rx_cmd_decoder
// Table of complete frames plus hand-written corner sequences. Each frame's
// expected command is queued when its bytes are driven and compared when the
// decoder hands it over (Cmd_valid && Cmd_ready).
// -----------------------------------------------------------------------------
module tb_rx_cmd_decoder;

    logic       CLK;
    logic       Reset;
    logic [7:0] RX_data;
    logic       RX_valid;
    logic       Cmd_ready;
    logic       Cmd_valid;
    logic [1:0] Cmd_op;
    logic [3:0] Cmd_addr;
    logic [7:0] Cmd_data;
    logic [7:0] Cmd_opA;
    logic [7:0] Cmd_opB;
    logic [3:0] Cmd_func;
    logic       Frame_err;
    logic       Ovf_err;

    rx_cmd_decoder #(
        .Width      (8),
        .Addr_Width (4),
        .Timeout    (255)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .RX_data   (RX_data),
        .RX_valid  (RX_valid),
        .Cmd_ready (Cmd_ready),
        .Cmd_valid (Cmd_valid),
        .Cmd_op    (Cmd_op),
        .Cmd_addr  (Cmd_addr),
        .Cmd_data  (Cmd_data),
        .Cmd_opA   (Cmd_opA),
        .Cmd_opB   (Cmd_opB),
        .Cmd_func  (Cmd_func),
        .Frame_err (Frame_err),
        .Ovf_err   (Ovf_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] func;
    } exp_t;

    // Frame bytes are left-aligned in 'bytes' (byte 0 in [31:24]).
    typedef struct {
        logic [31:0] bytes;
        int          n;
        int          gap;          // idle cycles between bytes
        int          ready_delay;  // 0: Cmd_ready high throughout
        exp_t        exp;
    } vec_t;

    int   checks;
    int   errors;
    int   frame_err_seen;
    int   ovf_err_seen;
    exp_t sb_q[$];
    exp_t mon_exp;
    exp_t mon_got;
    vec_t vecs[8];

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_valid = 1'b1;
        RX_data  = b;
        tick();
        RX_valid = 1'b0;
        RX_data  = 8'h00;
    endtask

    function automatic exp_t mk_exp(input logic [1:0] op, input logic [3:0] addr,
                                    input logic [7:0] data, input logic [7:0] opa,
                                    input logic [7:0] opb, input logic [3:0] func);
        exp_t e;
        e.op   = op;
        e.addr = addr;
        e.data = data;
        e.opa  = opa;
        e.opb  = opb;
        e.func = func;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [31:0] bytes, input int n, input int gap,
                                    input int ready_delay, input exp_t e);
        vec_t v;
        v.bytes       = bytes;
        v.n           = n;
        v.gap         = gap;
        v.ready_delay = ready_delay;
        v.exp         = e;
        return v;
    endfunction

    // Drive one whole frame, check issue latency, hold and release.
    task automatic send_frame(input string name, input vec_t v);
        logic [31:0] bb;
        logic        hold_ok;
        bb = v.bytes;
        sb_q.push_back(v.exp);
        Cmd_ready = (v.ready_delay == 0);
        for (int i = 0; i < v.n; i++) begin
            if (i == v.n - 1) begin
                check({name, "_no_early_valid"}, 64'(Cmd_valid), 64'd0);
            end
            send_byte(bb[31-8*i -: 8]);
            if (i < v.n - 1) begin
                repeat (v.gap) tick();
            end
        end
        check({name, "_latency"}, 64'(Cmd_valid), 64'd1);
        if (v.ready_delay > 0) begin
            hold_ok = 1'b1;
            repeat (v.ready_delay) begin
                tick();
                if (Cmd_valid !== 1'b1) hold_ok = 1'b0;
            end
            check({name, "_hold"}, 64'(hold_ok), 64'd1);
            Cmd_ready = 1'b1;
        end
        tick();
        Cmd_ready = 1'b0;
        check({name, "_release"}, 64'(Cmd_valid), 64'd0);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge CLK) begin
        if (Frame_err === 1'b1) frame_err_seen++;
        if (Ovf_err === 1'b1) ovf_err_seen++;
        if (Reset && Cmd_valid && Cmd_ready) begin
            checks++;
            mon_got = mk_exp(Cmd_op, Cmd_addr, Cmd_data, Cmd_opA, Cmd_opB, Cmd_func);
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_cmd: got %0h expected none", mon_got);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_cmd: got %0h expected %0h", mon_got, mon_exp);
                end else begin
                    $display("cmd op=%0d addr=%h data=%h opA=%h opB=%h func=%h",
                             Cmd_op, Cmd_addr, Cmd_data, Cmd_opA, Cmd_opB, Cmd_func);
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int fe0;
        int ov0;
        checks         = 0;
        errors         = 0;
        frame_err_seen = 0;
        ovf_err_seen   = 0;
        Reset          = 1'b0;
        RX_valid       = 1'b0;
        RX_data        = 8'h00;
        Cmd_ready      = 1'b0;

        // Expected fields include values kept from earlier commands.
        //                 bytes         n gap rdy        op    addr  data   opA    opB    func
        vecs[0] = mk_vec(32'hAA053C00, 3, 0, 0, mk_exp(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0));
        vecs[1] = mk_vec(32'hBB020000, 2, 0, 2, mk_exp(2'd1, 4'h2, 8'h3C, 8'h00, 8'h00, 4'h0));
        vecs[2] = mk_vec(32'hCC123401, 4, 2, 0, mk_exp(2'd2, 4'h2, 8'h3C, 8'h12, 8'h34, 4'h1));
        vecs[3] = mk_vec(32'hDD030000, 2, 0, 1, mk_exp(2'd3, 4'h2, 8'h3C, 8'h12, 8'h34, 4'h3));
        vecs[4] = mk_vec(32'hAA0FA500, 3, 1, 0, mk_exp(2'd0, 4'hF, 8'hA5, 8'h12, 8'h34, 4'h3));
        vecs[5] = mk_vec(32'hBBF70000, 2, 0, 3, mk_exp(2'd1, 4'h7, 8'hA5, 8'h12, 8'h34, 4'h3));
        vecs[6] = mk_vec(32'hCCFF009E, 4, 0, 0, mk_exp(2'd2, 4'h7, 8'hA5, 8'hFF, 8'h00, 4'hE));
        vecs[7] = mk_vec(32'hDD300000, 2, 0, 0, mk_exp(2'd3, 4'h7, 8'hA5, 8'hFF, 8'h00, 4'h0));

        tick();
        tick();
        check("reset_outputs",
              64'({Cmd_valid, Cmd_op, Cmd_addr, Cmd_data, Cmd_opA, Cmd_opB, Cmd_func, Frame_err, Ovf_err}),
              64'd0);
        Reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            send_frame($sformatf("vec%0d", i), vecs[i]);
        end
        check("table_no_frame_err", 64'(frame_err_seen), 64'd0);
        check("table_no_ovf_err", 64'(ovf_err_seen), 64'd0);

        // ALU frame held pending for 10 cycles, stray byte overflows
        sb_q.push_back(mk_exp(2'd2, 4'h7, 8'hA5, 8'h12, 8'h34, 4'h1));
        Cmd_ready = 1'b0;
        send_byte(8'hCC);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h01);
        check("alu_latency", 64'(Cmd_valid), 64'd1);
        ov0 = ovf_err_seen;
        repeat (3) tick();
        send_byte(8'h55);
        check("ovf_pulse", 64'(Ovf_err), 64'd1);
        check("ovf_valid_kept", 64'(Cmd_valid), 64'd1);
        repeat (6) tick();
        check("alu_hold_fields", 64'({Cmd_valid, Cmd_op, Cmd_opA, Cmd_opB, Cmd_func}),
              64'({1'b1, 2'd2, 8'h12, 8'h34, 4'h1}));
        Cmd_ready = 1'b1;
        tick();
        Cmd_ready = 1'b0;
        check("alu_release", 64'(Cmd_valid), 64'd0);
        check("ovf_single_pulse", 64'(ovf_err_seen - ov0), 64'd1);

        // Unknown command byte
        fe0 = frame_err_seen;
        send_byte(8'h77);
        check("bad_cmd_pulse", 64'(Frame_err), 64'd1);
        check("bad_cmd_no_valid", 64'(Cmd_valid), 64'd0);
        tick();
        check("bad_cmd_single_pulse", 64'(frame_err_seen - fe0), 64'd1);
        send_frame("rd_after_bad", mk_vec(32'hBB020000, 2, 0, 0,
                   mk_exp(2'd1, 4'h2, 8'hA5, 8'h12, 8'h34, 4'h1)));

        // Timeout: count is 0 after the byte, reaches 255 after 255 idle
        // cycles; the next silent cycle aborts.
        fe0 = frame_err_seen;
        send_byte(8'hAA);
        repeat (255) tick();
        check("timeout_not_early", 64'(frame_err_seen - fe0), 64'd0);
        tick();
        check("timeout_pulse", 64'(Frame_err), 64'd1);
        tick();
        check("timeout_single_pulse", 64'(frame_err_seen - fe0), 64'd1);
        send_frame("rd_after_timeout", mk_vec(32'hBB030000, 2, 0, 0,
                   mk_exp(2'd1, 4'h3, 8'hA5, 8'h12, 8'h34, 4'h1)));

        // Bytes landing exactly in the expiry cycle are accepted
        fe0 = frame_err_seen;
        send_frame("wr_at_timeout", mk_vec(32'hAA095A00, 3, 255, 0,
                   mk_exp(2'd0, 4'h9, 8'h5A, 8'h12, 8'h34, 4'h1)));
        check("timeout_edge_no_abort", 64'(frame_err_seen - fe0), 64'd0);

        // Reset mid-frame clears everything silently
        fe0 = frame_err_seen;
        send_byte(8'hCC);
        send_byte(8'h12);
        Reset = 1'b0;
        tick();
        check("midframe_reset_outputs",
              64'({Cmd_valid, Cmd_op, Cmd_addr, Cmd_data, Cmd_opA, Cmd_opB, Cmd_func, Frame_err, Ovf_err}),
              64'd0);
        Reset = 1'b1;
        tick();
        check("midframe_reset_no_err", 64'(frame_err_seen - fe0), 64'd0);
        send_frame("nop_after_reset", mk_vec(32'hDD030000, 2, 0, 0,
                   mk_exp(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3)));

        // Back-to-back: next command byte coincides with the handshake
        ov0 = ovf_err_seen;
        fe0 = frame_err_seen;
        sb_q.push_back(mk_exp(2'd1, 4'h4, 8'h00, 8'h00, 8'h00, 4'h3));
        Cmd_ready = 1'b0;
        send_byte(8'hBB);
        send_byte(8'h04);
        check("b2b_first_valid", 64'(Cmd_valid), 64'd1);
        tick();
        sb_q.push_back(mk_exp(2'd3, 4'h4, 8'h00, 8'h00, 8'h00, 4'h6));
        Cmd_ready = 1'b1;
        send_byte(8'hDD);
        Cmd_ready = 1'b0;
        check("b2b_handshake_release", 64'(Cmd_valid), 64'd0);
        send_byte(8'h06);
        check("b2b_second_valid", 64'(Cmd_valid), 64'd1);
        Cmd_ready = 1'b1;
        tick();
        Cmd_ready = 1'b0;
        check("b2b_second_release", 64'(Cmd_valid), 64'd0);
        check("b2b_no_ovf", 64'(ovf_err_seen - ov0), 64'd0);
        check("b2b_no_frame_err", 64'(frame_err_seen - fe0), 64'd0);

        tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("total_frame_err", 64'(frame_err_seen), 64'd2);
        check("total_ovf_err", 64'(ovf_err_seen), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_cmd_decoder.md
RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

Interface
REQ-001 SHALL have parameter Width, default 8: byte width of the received data bus.
REQ-002 SHALL have parameter Addr_Width, default 4: number of address bits taken from the address byte.
REQ-003 SHALL have parameter Timeout, default 255: maximum idle cycles allowed between bytes inside a frame.
REQ-004 SHALL have port CLK, input, 1 bit: single clock.
REQ-005 SHALL have port Reset, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port RX_data, input, Width bits: synchronized byte from the upstream enable-based data synchronizer.
REQ-007 SHALL have port RX_valid, input, 1 bit: one-cycle pulse marking RX_data valid.
REQ-008 SHALL have port Cmd_ready, input, 1 bit: consumer accepts the pending command.
REQ-009 SHALL have port Cmd_valid, output, 1 bit: decoded command pending.
REQ-010 SHALL have port Cmd_op, output, 2 bits: 00 WR, 01 RD, 10 ALU_OP, 11 ALU_NOP.
REQ-011 SHALL have port Cmd_addr, output, Addr_Width bits: register address.
REQ-012 SHALL have port Cmd_data, output, Width bits: write data.
REQ-013 SHALL have ports Cmd_opA and Cmd_opB, output, Width bits each: ALU operands.
REQ-014 SHALL have port Cmd_func, output, 4 bits: ALU function.
REQ-015 SHALL have ports Frame_err and Ovf_err, output, 1 bit each: one-cycle error pulses.

Function
REQ-016 SHALL decode the command byte in IDLE as follows: 0xAA -> GET_ADDR,GET_DATA (WR); 0xBB -> GET_ADDR (RD); 0xCC -> GET_OPA,GET_OPB,GET_FUNC (ALU_OP); 0xDD -> GET_FUNC (ALU_NOP).
REQ-017 SHALL, on any other byte received in IDLE, pulse Frame_err for 1 cycle and remain in IDLE.
REQ-018 SHALL advance one field state per RX_valid only, and SHALL ignore RX_data while RX_valid is 0.
REQ-019 SHALL take Cmd_addr from RX_data[Addr_Width-1:0] and Cmd_func from RX_data[3:0].
REQ-020 SHALL register each field when its byte arrives, and SHALL keep fields not used by the current op at their previous values.
REQ-021 SHALL enter ISSUE and assert Cmd_valid on the cycle after the final byte's RX_valid (latency 1 cycle).
REQ-022 SHALL hold Cmd_valid and all Cmd_* outputs stable in ISSUE until Cmd_ready is 1, then return to IDLE with Cmd_valid at 0 on the next cycle.
REQ-023 SHALL, on RX_valid in ISSUE without Cmd_ready, drop the byte, pulse Ovf_err for 1 cycle, and leave the state unchanged.
REQ-024 SHALL, on RX_valid in the same cycle as Cmd_valid and Cmd_ready, decode the byte as an IDLE command byte without raising Ovf_err.
REQ-025 SHALL clear the inter-byte counter on every RX_valid and on entry to IDLE, and SHALL increment it only in GET_* states.
REQ-026 SHALL, when the counter reaches Timeout in a GET_* state with no RX_valid that cycle, abort the frame, pulse Frame_err, and return to IDLE.
REQ-027 SHALL treat RX_valid arriving in the timeout cycle as a normal byte, with no abort.
REQ-028 SHALL size the counter to hold Timeout with saturation and no wrap-around.

Reset
REQ-029 SHALL, while Reset is 0 at a CLK edge, set the state to IDLE, the counter to 0, and every output (Cmd_valid, Cmd_op, Cmd_addr, Cmd_data, Cmd_opA, Cmd_opB, Cmd_func, Frame_err, Ovf_err) to 0.
REQ-030 SHALL, on reset mid-frame or in ISSUE, discard the partial or pending command with no error pulse.

Structure
REQ-031 SHALL place the command byte constants (0xAA, 0xBB, 0xCC, 0xDD), the Cmd_op encodings and the state encoding in shared package rx_cmd_pkg.
REQ-032 SHALL implement the inter-byte timeout counter as sub-module frame_timer (inputs clear and enable; output expired).
REQ-033 SHALL use a single FSM with states IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUNC, ISSUE.

Verification
REQ-034 SHALL test WR: bytes 0xAA,0x05,0x3C with Cmd_ready=1 -> one Cmd_valid cycle, Cmd_op=00, Cmd_addr=5, Cmd_data=0x3C.
REQ-035 SHALL test ALU_OP: bytes 0xCC,0x12,0x34,0x01 with Cmd_ready held 0 for 10 cycles -> Cmd_valid stays 1 with Cmd_opA=0x12, Cmd_opB=0x34, Cmd_func=1 until Cmd_ready, and a byte sent meanwhile produces Ovf_err.
REQ-036 SHALL test a bad command: byte 0x77 -> Frame_err for 1 cycle, no Cmd_valid; a following 0xBB,0x02 -> RD, Cmd_addr=2.
REQ-037 SHALL test timeout: 0xAA then no byte for 255 cycles -> Frame_err, IDLE; a second case with the byte arriving at cycle 255 -> no abort.
REQ-038 SHALL test reset mid-frame: 0xCC,0x12 then Reset=0 for 1 cycle -> all outputs 0; a following 0xDD,0x03 -> ALU_NOP, Cmd_func=3.
REQ-039 SHALL test back-to-back: RX_valid coincident with the Cmd_ready handshake -> next command decodes with no Ovf_err.
